round_judge: RTL and testbench

ROUND_JUDGE -- requirements
Module: round_judge

---
 rtl/game_pkg.sv | 95 +++++++++
 rtl/btn_conditioner.sv | 74 +++++++
 rtl/round_judge.sv | 129 ++++++++++++
 tb/tb_round_judge.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the dice-game judge: result codes, state codes, widths, scoring rule.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   result_e       round outcome codes driven on choose_result
//   CTRL_*         game controller state codes (the judge is active in CTRL_CHOOSE)
//   judge_state_e  round_judge FSM states, built on legacy localparam encodings
//   SUM_* / MAX_TURNS  scoring constants
//   judge()        the pure scoring rule used in the EVAL state
package game_pkg;

  localparam int DIE_W  = 3;
  localparam int SUM_W  = 4;
  localparam int TURN_W = 4;

  // Round outcome; 2'b11 is never produced.
  typedef enum logic [1:0] {
    RES_CONTINUE = 2'b00,
    RES_LOST     = 2'b01,
    RES_WON      = 2'b10
  } result_e;

  // Game controller state codes.
  localparam logic [1:0] CTRL_IDLE   = 2'd0;
  localparam logic [1:0] CTRL_ROLL   = 2'd1;
  localparam logic [1:0] CTRL_CHOOSE = 2'd2;
  localparam logic [1:0] CTRL_OVER   = 2'd3;

  // Judge FSM encodings, kept as plain constants for older code that compares raw bits.
  localparam logic [2:0] J_IDLE     = 3'd0;
  localparam logic [2:0] J_CAPTURE  = 3'd1;
  localparam logic [2:0] J_WAIT_BTN = 3'd2;
  localparam logic [2:0] J_EVAL     = 3'd3;
  localparam logic [2:0] J_PULSE    = 3'd4;
  localparam logic [2:0] J_DONE     = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE     = J_IDLE,
    ST_CAPTURE  = J_CAPTURE,
    ST_WAIT_BTN = J_WAIT_BTN,
    ST_EVAL     = J_EVAL,
    ST_PULSE    = J_PULSE,
    ST_DONE     = J_DONE
  } judge_state_e;

  // Scoring constants.
  localparam logic [SUM_W-1:0]  SUM_SEVEN  = 4'd7;
  localparam logic [SUM_W-1:0]  SUM_ELEVEN = 4'd11;
  localparam logic [SUM_W-1:0]  SUM_TWO    = 4'd2;
  localparam logic [SUM_W-1:0]  SUM_THREE  = 4'd3;
  localparam logic [SUM_W-1:0]  SUM_TWELVE = 4'd12;
  localparam logic [TURN_W-1:0] MAX_TURNS  = 4'd15;

  typedef struct packed {
    result_e          result;
    logic [SUM_W-1:0] point;
  } verdict_t;

  // Scoring rule for one round. Turn 0 is treated like any later turn.
  // A round that would continue on the last representable turn is scored as
  // lost so the controller's 4-bit turn counter can never wrap.
  function automatic verdict_t judge(
    input logic [TURN_W-1:0] turns,
    input logic [SUM_W-1:0]  sum,
    input logic              die_bad,
    input logic [SUM_W-1:0]  point
  );
    verdict_t v;
    v.result = RES_CONTINUE;
    v.point  = point;
    if (die_bad) begin
      v.result = RES_LOST;
    end else if (turns == 4'd1) begin
      if (sum == SUM_SEVEN || sum == SUM_ELEVEN) begin
        v.result = RES_WON;
      end else if (sum == SUM_TWO || sum == SUM_THREE || sum == SUM_TWELVE) begin
        v.result = RES_LOST;
      end else begin
        v.point = sum;
      end
    end else begin
      if (sum == point) begin
        v.result = RES_WON;
      end else if (sum == SUM_SEVEN) begin
        v.result = RES_LOST;
      end
    end
    if (v.result == RES_CONTINUE && turns == MAX_TURNS) begin
      v.result = RES_LOST;
    end
    return v;
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Turns the raw asynchronous confirm button into a one-cycle press strobe.
// Latency: press 2 clk after btn rises (plain), or after DEBOUNCE_CYCLES high samples of the synced btn (debounced).
// Backpressure: none; press is a single-cycle strobe and is lost if the consumer is not listening.
//
// Ports:
//   clk, rst   clock and synchronous active-low reset
//   btn        raw active-high button, asynchronous to clk
//   press      one-cycle strobe on each registered press
// Macro ROUND_JUDGE_DEBOUNCE_EN: when defined, a consecutive-high counter follows
// the synchronizer; when undefined, press is the rising edge of the synced btn.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  // Two-flop synchronizer for the asynchronous button.
  logic sync_1;
  logic sync_2;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= btn;
      sync_2 <= sync_1;
    end
  end

  // A zero-length debounce window is meaningless; such a configuration
  // elaborates this marker block so it is easy to spot in the hierarchy.
  if (DEBOUNCE_CYCLES < 1) begin : g_cfg_invalid_debounce
  end

`ifdef ROUND_JUDGE_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  // Counts consecutive high samples of sync_2 and saturates at DEBOUNCE_CYCLES,
  // so a long hold yields exactly one press.
  logic [CNT_W-1:0] hi_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      hi_cnt <= '0;
    end else if (!sync_2) begin
      hi_cnt <= '0;
    end else if (hi_cnt != CNT_W'(DEBOUNCE_CYCLES)) begin
      hi_cnt <= hi_cnt + CNT_W'(1);
    end
  end

  // The conditioned level rises when the count reaches DEBOUNCE_CYCLES; the
  // strobe marks the cycle whose high sample completes the window.
  assign press = sync_2 && (hi_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
`else
  // Plain build: edge detect directly on the synchronized level.
  logic sync_3;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_3 <= 1'b0;
    end else begin
      sync_3 <= sync_2;
    end
  end

  assign press = sync_2 && !sync_3;
`endif

endmodule

// File: rtl/round_judge.sv
// Judges one dice round per enable window: captures dice, waits for a confirm press, scores, strobes the result.
// Latency: EVAL occupies the cycle after the press is registered; pulse_o rises 1 cycle later.
// Backpressure: none; one pulse_o per enable assertion, enable low aborts a round that has not scored yet.
//
// Ports:
//   clk, rst       clock and synchronous active-low reset
//   enable         high while the controller is in its CHOOSE state
//   turns          1-based turn number from the controller
//   die_a, die_b   die faces 1..6; 0 or 7 marks a bad roll
//   btn            raw player confirm button
//   pulse_o        one-cycle strobe to the controller, choose_result valid with it
//   choose_result  00 CONTINUE, 01 LOST, 10 WON; held until the next score
//   point          established point, 0 when none
//   busy           high whenever the FSM is outside IDLE
// Macro ROUND_JUDGE_DEBOUNCE_EN enables the button debounce counter (see btn_conditioner).
module round_judge
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [TURN_W-1:0] turns,
  input  logic [DIE_W-1:0]  die_a,
  input  logic [DIE_W-1:0]  die_b,
  input  logic              btn,
  output logic              pulse_o,
  output logic [1:0]        choose_result,
  output logic [SUM_W-1:0]  point,
  output logic              busy
);

  judge_state_e     state;
  result_e          result_q;
  logic [SUM_W-1:0] point_q;
  logic [SUM_W-1:0] sum_q;
  logic             die_bad_q;
  logic             press;
  verdict_t         verdict;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn),
    .press(press)
  );

  // Dice are summed at full 4-bit width so 7+7 cannot alias a legal sum.
  logic [SUM_W-1:0] dice_sum;
  logic             dice_bad;

  assign dice_sum = {1'b0, die_a} + {1'b0, die_b};
  assign dice_bad = (die_a == 3'd0) || (die_a == 3'd7) ||
                    (die_b == 3'd0) || (die_b == 3'd7);

  assign verdict = judge(turns, sum_q, die_bad_q, point_q);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      result_q  <= RES_CONTINUE;
      point_q   <= '0;
      sum_q     <= '0;
      die_bad_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable) state <= ST_CAPTURE;
        end

        ST_CAPTURE: begin
          // An aborted capture must leave point untouched, so the first-turn
          // clear is only committed when the round actually proceeds.
          if (!enable) begin
            state <= ST_IDLE;
          end else begin
            sum_q     <= dice_sum;
            die_bad_q <= dice_bad;
            if (turns == 4'd1) point_q <= '0;
            state <= ST_WAIT_BTN;
          end
        end

        ST_WAIT_BTN: begin
          // Only strobes seen here count; a button held from before CAPTURE
          // produced its edge earlier and is ignored.
          if (!enable) begin
            state <= ST_IDLE;
          end else if (press) begin
            state <= ST_EVAL;
          end
        end

        ST_EVAL: begin
          if (!enable) begin
            state <= ST_IDLE;
          end else begin
            result_q <= verdict.result;
            point_q  <= verdict.point;
            state    <= ST_PULSE;
          end
        end

        ST_PULSE: begin
          state <= ST_DONE;
        end

        ST_DONE: begin
          if (!enable) state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Decoded straight from state, so a reset edge during PULSE clears the
  // strobe on the very next cycle and nothing is left to replay it.
  assign pulse_o       = (state == ST_PULSE);
  assign busy          = (state != ST_IDLE);
  assign choose_result = result_q;
  assign point         = point_q;

endmodule

// File: tb/tb_round_judge.sv
module tb_round_judge;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [3:0] turns;
  logic [2:0] die_a;
  logic [2:0] die_b;
  logic       btn;
  logic       pulse_o;
  logic [1:0] choose_result;
  logic [3:0] point;
  logic       busy;

  int tests = 0;
  int fails = 0;

  // Posedges counted from the btn rise (driven on a negedge) to the first
  // sample with pulse_o high: sync (2) + edge/debounce + EVAL + PULSE.
`ifdef ROUND_JUDGE_DEBOUNCE_EN
  localparam int EXP_LAT = 19;
`else
  localparam int EXP_LAT = 4;
`endif

  always #5 clk = ~clk;

  round_judge #(
    .DEBOUNCE_CYCLES(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .turns        (turns),
    .die_a        (die_a),
    .die_b        (die_b),
    .btn          (btn),
    .pulse_o      (pulse_o),
    .choose_result(choose_result),
    .point        (point),
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  int         n_pulse;
  int         lat;
  logic [1:0] res_at_pulse;

  // Holds btn high for 'hold' cycles inside a bounded observation window,
  // counting pulses and capturing the result during the first one.
  task automatic press_btn(input int hold, input int window);
    n_pulse      = 0;
    lat          = 0;
    res_at_pulse = 2'b11;
    @(negedge clk);
    btn = 1'b1;
    for (int k = 1; k <= window; k++) begin
      @(posedge clk);
      #1;
      if (pulse_o === 1'b1) begin
        n_pulse++;
        if (n_pulse == 1) begin
          lat          = k;
          res_at_pulse = choose_result;
        end
      end
      if (k == hold) begin
        @(negedge clk);
        btn = 1'b0;
      end
    end
    @(negedge clk);
    btn = 1'b0;
  endtask

  task automatic start_round(input logic [3:0] t, input logic [2:0] a, input logic [2:0] b);
    @(negedge clk);
    turns  = t;
    die_a  = a;
    die_b  = b;
    enable = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic end_round();
    @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic round(input string tag, input logic [3:0] t, input logic [2:0] a,
                       input logic [2:0] b, input logic [1:0] exp_res, input logic [3:0] exp_pt);
    start_round(t, a, b);
    press_btn(20, 40);
    check({tag, "_pulses"}, 8'(n_pulse), 8'd1);
    check({tag, "_result"}, {6'd0, res_at_pulse}, {6'd0, exp_res});
    check({tag, "_point"}, {4'd0, point}, {4'd0, exp_pt});
    end_round();
  endtask

  initial begin
    bit seen;
    rst    = 1'b0;
    enable = 1'b0;
    btn    = 1'b0;
    turns  = 4'd0;
    die_a  = 3'd0;
    die_b  = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pulse", {7'd0, pulse_o}, 8'd0);
    check("rst_result", {6'd0, choose_result}, 8'd0);
    check("rst_point", {4'd0, point}, 8'd0);
    check("rst_busy", {7'd0, busy}, 8'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // First turn natural, with latency and one-pulse-per-enable checks.
    start_round(4'd1, 3'd3, 3'd4);
    check("r1_busy", {7'd0, busy}, 8'd1);
    press_btn(20, 40);
    check("r1_pulses", 8'(n_pulse), 8'd1);
    check("r1_latency", 8'(lat), 8'(EXP_LAT));
    check("r1_result", {6'd0, res_at_pulse}, 8'd2);
    check("r1_point", {4'd0, point}, 8'd0);
    press_btn(20, 40);
    check("r1_second_press", 8'(n_pulse), 8'd0);
    check("r1_result_hold", {6'd0, choose_result}, 8'd2);
    end_round();
    check("r1_idle_busy", {7'd0, busy}, 8'd0);

    round("point4", 4'd1, 3'd2, 3'd2, 2'b00, 4'd4);
    round("hit4", 4'd2, 3'd1, 3'd3, 2'b10, 4'd4);
    round("point5", 4'd1, 3'd2, 3'd3, 2'b00, 4'd5);
    round("seven_out", 4'd2, 3'd6, 3'd1, 2'b01, 4'd5);
    round("turn15", 4'd15, 3'd4, 3'd4, 2'b01, 4'd5);
    round("cont", 4'd3, 3'd4, 3'd4, 2'b00, 4'd5);
    round("turn0", 4'd0, 3'd2, 3'd3, 2'b10, 4'd5);
    round("die_a7", 4'd2, 3'd7, 3'd3, 2'b01, 4'd5);
    round("die_b0", 4'd3, 3'd3, 3'd0, 2'b01, 4'd5);
    round("craps2", 4'd1, 3'd1, 3'd1, 2'b01, 4'd0);
    round("craps12", 4'd1, 3'd6, 3'd6, 2'b01, 4'd0);
    round("eleven", 4'd1, 3'd5, 3'd6, 2'b10, 4'd0);
    round("point10", 4'd1, 3'd4, 3'd6, 2'b00, 4'd10);
    round("hit_t15", 4'd15, 3'd6, 3'd4, 2'b10, 4'd10);
    round("craps3", 4'd1, 3'd1, 3'd2, 2'b01, 4'd0);
    round("point6", 4'd1, 3'd3, 3'd3, 2'b00, 4'd6);

    // Abort in WAIT_BTN: a later press must do nothing.
    start_round(4'd2, 3'd3, 3'd3);
    check("abort_busy_wait", {7'd0, busy}, 8'd1);
    @(negedge clk);
    enable = 1'b0;
    @(posedge clk);
    #1;
    check("abort_busy_idle", {7'd0, busy}, 8'd0);
    press_btn(20, 30);
    check("abort_pulses", 8'(n_pulse), 8'd0);
    check("abort_point", {4'd0, point}, 8'd6);
    check("abort_result", {6'd0, choose_result}, 8'd0);
    repeat (3) @(negedge clk);

`ifdef ROUND_JUDGE_DEBOUNCE_EN
    // A 10-cycle glitch is filtered; a 16-cycle hold registers.
    start_round(4'd2, 3'd3, 3'd3);
    press_btn(10, 40);
    check("glitch_pulses", 8'(n_pulse), 8'd0);
    press_btn(16, 40);
    check("hold16_pulses", 8'(n_pulse), 8'd1);
    check("hold16_latency", 8'(lat), 8'd19);
    check("hold16_result", {6'd0, res_at_pulse}, 8'd2);
    end_round();
`endif

    // Reset landing on the PULSE cycle.
    start_round(4'd2, 3'd3, 3'd3);
    seen = 1'b0;
    @(negedge clk);
    btn = 1'b1;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (pulse_o === 1'b1) seen = 1'b1;
    end
    check("rstp_pulse_seen", {7'd0, seen}, 8'd1);
    check("rstp_result_before", {6'd0, choose_result}, 8'd2);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rstp_pulse", {7'd0, pulse_o}, 8'd0);
    check("rstp_busy", {7'd0, busy}, 8'd0);
    check("rstp_result", {6'd0, choose_result}, 8'd0);
    check("rstp_point", {4'd0, point}, 8'd0);
    @(negedge clk);
    btn = 1'b0;
    rst = 1'b1;
    n_pulse = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (pulse_o === 1'b1) n_pulse++;
    end
    check("rstp_no_replay", 8'(n_pulse), 8'd0);
    end_round();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
